i2s_audio_tx: RTL

Output stage that consumes the 9-bit unsigned mixed sample from `audio_processing_unit` and serializes it as a standard Philips I2S stereo stream for an external audio DAC. Both channels carry the same sample. The block generates BCLK and LRCLK from the system clock and converts the offset-binary sample to 16-bit two's complement. It holds the most recent sample, loads it once per I2S frame, and reports underruns when no fresh sample arrived.

---
 rtl/i2s_audio_tx_if.sv | 21 ++
 rtl/i2s_audio_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/i2s_audio_tx_if.sv
// Sample-in / I2S-out signal bundle for i2s_audio_tx.
// The producer (mixer side) uses master; the transmitter uses slave.
interface i2s_audio_tx_if;
    logic [8:0] i_sample;
    logic       i_sample_valid;
    logic       o_bclk;
    logic       o_lrclk;
    logic       o_sdata;
    logic       o_sample_req;
    logic       o_underrun;

    modport master (
        output i_sample, i_sample_valid,
        input  o_bclk, o_lrclk, o_sdata, o_sample_req, o_underrun
    );

    modport slave (
        input  i_sample, i_sample_valid,
        output o_bclk, o_lrclk, o_sdata, o_sample_req, o_underrun
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// Philips I2S stereo transmitter: holds the latest 9-bit offset-binary sample,
// converts it to 16-bit two's complement and plays it on both channels once per frame.
module i2s_audio_tx #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    i2s_audio_tx_if.slave bus
);

    localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]       slot_q, slot_d;
    logic [15:0]      word_q, word_d;
    logic [8:0]       hold_q, hold_d;
    logic             fresh_q, fresh_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             sample_req_q, sample_req_d;
    logic             underrun_q, underrun_d;

    logic       tick;
    logic       fall;
    logic [4:0] slot_next;
    logic [3:0] bit_idx;

    assign tick      = (div_cnt_q == CNT_MAX);
    assign fall      = tick & bclk_q;
    assign slot_next = slot_q + 5'd1;
    // Slot s carries word[16-s] in the left half and word[32-s] in the right;
    // both reduce to (-s) mod 16, and slot 0 lands on bit 0, which is always 0.
    assign bit_idx   = 4'd0 - slot_next[3:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        div_cnt_d    = tick ? '0 : div_cnt_q + CNT_W'(1);
        slot_d       = slot_q;
        word_d       = word_q;
        hold_d       = hold_q;
        fresh_d      = fresh_q;
        bclk_d       = tick ? ~bclk_q : bclk_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        sample_req_d = 1'b0;
        underrun_d   = 1'b0;

        if (fall) begin
            slot_d  = slot_next;
            lrclk_d = slot_next[4];
            if (slot_next == 5'd0) begin
                word_d       = {~hold_q[8], hold_q[7:0], 7'b0};
                sdata_d      = 1'b0;
                sample_req_d = 1'b1;
                underrun_d   = ~fresh_q;
                fresh_d      = 1'b0;
            end else begin
                sdata_d = word_q[bit_idx];
            end
        end

        // A capture in the load cycle lands after the clear, so it counts for the next frame.
        if (bus.i_sample_valid) begin
            hold_d  = bus.i_sample;
            fresh_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (i_reset) begin
            div_cnt_q    <= '0;
            slot_q       <= 5'd0;
            word_q       <= 16'h0000;
            hold_q       <= 9'h100;
            fresh_q      <= 1'b0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            slot_q       <= slot_d;
            word_q       <= word_d;
            hold_q       <= hold_d;
            fresh_q      <= fresh_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.o_bclk       = bclk_q;
    assign bus.o_lrclk      = lrclk_q;
    assign bus.o_sdata      = sdata_q;
    assign bus.o_sample_req = sample_req_q;
    assign bus.o_underrun   = underrun_q;

endmodule
